note_sequencer: RTL and testbench

Parametrised record/playback engine for the fret-bar guitar front end. It samples string contacts and bar presses over tempo-timed beat windows and encodes each window into a one-hot note frame. Frames are stored in an internal DEPTH-entry memory and replayed on the same beat grid, once or looped. It sits between the GPIO input conditioning and the audio module, and replaces the fixed 6×4, 64-entry record path.

---
 rtl/note_sequencer_pkg.sv | 39 +++
 rtl/note_sequencer_if.sv | 45 ++++
 rtl/note_sequencer_beat_timer.sv | 50 +++++
 rtl/note_sequencer.sv | 167 ++++++++++++++++
 tb/tb_note_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/note_sequencer_pkg.sv
// =============================================================================
// Module      : note_seq_pkg
// Description : Shared types, tempo divider table and frame sizing helpers for
//               the note record/playback engine.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

package note_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_e;

    // Cycles per beat at the 75 MHz reference clock, indexed by speed.
    localparam int unsigned DIV_TABLE [8] = '{
        32'd75000000, 32'd50000000, 32'd37500000, 32'd30000000,
        32'd25000000, 32'd21428571, 32'd16666667, 32'd13636364
    };

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned frame_width(input int unsigned num_strings,
                                                input int unsigned num_bars);
        return num_strings * (num_bars + 1);
    endfunction

    function automatic int unsigned beat_div(input logic [2:0]  idx,
                                             input int unsigned scale);
        int unsigned d;
        d = DIV_TABLE[idx] / scale;
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/note_sequencer_if.sv
// =============================================================================
// Module      : note_sequencer_if
// Description : Command, input-contact and playback-output bundle of the note
//               sequencer; master drives commands, slave is the sequencer.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

interface note_sequencer_if
    import note_seq_pkg::*;
#(
    parameter int unsigned NUM_STRINGS = 6,
    parameter int unsigned NUM_BARS    = 4,
    parameter int unsigned DEPTH       = 64
);
    localparam int unsigned FRAME_W = frame_width(NUM_STRINGS, NUM_BARS);
    localparam int unsigned AW      = $clog2(DEPTH);

    logic                   cmd_record;
    logic                   cmd_play;
    logic                   cmd_stop;
    logic                   loop_en;
    logic [2:0]             speed;
    logic [NUM_STRINGS-1:0] strings;
    logic [NUM_BARS-1:0]    bars;
    logic [FRAME_W-1:0]     note_out;
    logic                   note_valid;
    logic                   beat;
    logic [1:0]             state;
    logic [AW:0]            rec_len;
    logic                   full;

    modport master (
        output cmd_record, cmd_play, cmd_stop, loop_en, speed, strings, bars,
        input  note_out, note_valid, beat, state, rec_len, full
    );

    modport slave (
        input  cmd_record, cmd_play, cmd_stop, loop_en, speed, strings, bars,
        output note_out, note_valid, beat, state, rec_len, full
    );

endinterface

`default_nettype wire

// File: rtl/note_sequencer_beat_timer.sv
// =============================================================================
// Module      : beat_timer
// Description : Tempo down-counter; pulses beat when it reaches zero and then
//               reloads from the scaled divider table at the current speed.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module beat_timer
    import note_seq_pkg::*;
#(
    parameter int unsigned TICK_SCALE = 1
) (
    input  wire logic       clk,
    input  wire logic       resetn,
    input  wire logic       reload,
    input  wire logic [2:0] speed,
    output logic            beat
);
    localparam int unsigned CW = 32;

    logic [CW-1:0] div_tab [8];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    for (genvar gi = 0; gi < 8; gi++) begin : g_div
        assign div_tab[gi] = CW'(beat_div(3'(gi), TICK_SCALE));
    end

    // Loading div-1 puts the zero count exactly div cycles after the reload.
    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (reload || (cnt_q == '0)) begin
            cnt_d = div_tab[speed] - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// =============================================================================
// Module      : note_sequencer
// Description : Records string/bar contacts into one-hot note frames per beat
//               window and replays them on the same beat grid, once or looped.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned NUM_STRINGS = 6,
    parameter int unsigned NUM_BARS    = 4,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned TICK_SCALE  = 1
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    note_sequencer_if.slave  bus
);
    localparam int unsigned FRAME_W = frame_width(NUM_STRINGS, NUM_BARS);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned BW      = $clog2(NUM_BARS + 1);

    state_e                 state_q;
    logic [AW-1:0]          addr_q;
    logic [NUM_STRINGS-1:0] str_acc_q;
    logic [BW-1:0]          bar_acc_q;
    logic [AW:0]            rec_len_q;
    logic                   full_q;
    logic [FRAME_W-1:0]     note_out_q;
    logic                   note_valid_q;

    logic [FRAME_W-1:0]     mem [DEPTH];

    logic                   w_beat_raw;
    logic                   w_beat;
    logic                   w_start_rec;
    logic                   w_start_play;
    logic                   w_reload;
    logic                   w_wr_en;
    logic                   w_last;
    logic [BW-1:0]          w_bar_idx;
    logic [BW-1:0]          w_bar_max;
    logic [FRAME_W-1:0]     w_frame;

    // Command decode: stop outranks record, record outranks play.
    assign w_start_rec  = (state_q == ST_IDLE) && bus.cmd_record && !bus.cmd_stop;
    assign w_start_play = (state_q == ST_IDLE) && bus.cmd_play && !bus.cmd_record &&
                          !bus.cmd_stop && (rec_len_q != '0);
    assign w_reload     = w_start_rec || w_start_play;

    beat_timer #(
        .TICK_SCALE (TICK_SCALE)
    ) u_beat_timer (
        .clk    (clk),
        .resetn (resetn),
        .reload (w_reload),
        .speed  (bus.speed),
        .beat   (w_beat_raw)
    );

    assign w_beat  = w_beat_raw && (state_q != ST_IDLE);
    assign w_wr_en = (state_q == ST_RECORD) && w_beat && !bus.cmd_stop;
    assign w_last  = ({1'b0, addr_q} == (rec_len_q - (AW+1)'(1)));

    // Highest pressed bar, 1-based; 0 means no bar.
    always_comb begin
        w_bar_idx = '0;
        for (int i = 0; i < int'(NUM_BARS); i++) begin
            if (bus.bars[i]) begin
                w_bar_idx = BW'(i + 1);
            end
        end
    end

    assign w_bar_max = (w_bar_idx > bar_acc_q) ? w_bar_idx : bar_acc_q;

    for (genvar g = 0; g <= NUM_BARS; g++) begin : g_group
        for (genvar s = 0; s < NUM_STRINGS; s++) begin : g_string
            assign w_frame[g*NUM_STRINGS + s] = str_acc_q[s] && (bar_acc_q == BW'(g));
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[addr_q] <= w_frame;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            str_acc_q    <= '0;
            bar_acc_q    <= '0;
            rec_len_q    <= '0;
            full_q       <= 1'b0;
            note_out_q   <= '0;
            note_valid_q <= 1'b0;
        end else begin
            note_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (w_start_rec) begin
                        state_q   <= ST_RECORD;
                        addr_q    <= '0;
                        full_q    <= 1'b0;
                        str_acc_q <= '0;
                        bar_acc_q <= '0;
                    end else if (w_start_play) begin
                        state_q <= ST_PLAY;
                        addr_q  <= '0;
                    end
                end
                ST_RECORD: begin
                    if (bus.cmd_stop) begin
                        rec_len_q <= {1'b0, addr_q};
                        state_q   <= ST_IDLE;
                    end else if (w_beat) begin
                        addr_q    <= addr_q + AW'(1);
                        str_acc_q <= bus.strings;
                        bar_acc_q <= w_bar_idx;
                        if (addr_q == AW'(DEPTH - 1)) begin
                            rec_len_q <= (AW+1)'(DEPTH);
                            full_q    <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        str_acc_q <= str_acc_q | bus.strings;
                        bar_acc_q <= w_bar_max;
                    end
                end
                ST_PLAY: begin
                    if (bus.cmd_stop) begin
                        state_q <= ST_IDLE;
                    end else if (w_beat) begin
                        note_out_q   <= mem[addr_q];
                        note_valid_q <= 1'b1;
                        if (w_last) begin
                            if (bus.loop_en) begin
                                addr_q <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.note_out   = note_out_q;
    assign bus.note_valid = note_valid_q;
    assign bus.beat       = w_beat;
    assign bus.state      = state_q;
    assign bus.rec_len    = rec_len_q;
    assign bus.full       = full_q;

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// =============================================================================
// Module      : tb_note_sequencer
// Description : Directed bench for note_sequencer with a frame scoreboard.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_note_sequencer;
    import note_seq_pkg::*;

    localparam int NS    = 6;
    localparam int NB    = 4;
    localparam int DEPTH = 4;
    localparam int FW    = NS * (NB + 1);

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    note_sequencer_if #(.NUM_STRINGS(NS), .NUM_BARS(NB), .DEPTH(DEPTH)) bus ();

    note_sequencer #(
        .NUM_STRINGS (NS),
        .NUM_BARS    (NB),
        .DEPTH       (DEPTH),
        .TICK_SCALE  (5000000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int checks     = 0;
    int failures   = 0;
    int valid_seen = 0;
    logic          prev_beat = 1'b0;
    logic [FW-1:0] exp_q [$];
    logic [FW-1:0] model_mem [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] encode(input logic [NS-1:0] s, input logic [NB-1:0] b);
        int            g = 0;
        logic [FW-1:0] f = '0;
        for (int k = 0; k < NB; k++) if (b[k]) g = k + 1;
        for (int k = 0; k < NS; k++) if (s[k]) f[g*NS + k] = 1'b1;
        return f;
    endfunction

    task automatic pulse(input logic rec, input logic play, input logic stop);
        @(posedge clk); #1;
        bus.cmd_record = rec;
        bus.cmd_play   = play;
        bus.cmd_stop   = stop;
        @(posedge clk); #1;
        bus.cmd_record = 1'b0;
        bus.cmd_play   = 1'b0;
        bus.cmd_stop   = 1'b0;
    endtask

    task automatic wait_beat(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.beat && n < 100);
        if (!bus.beat) check("beat_timeout", 64'(bus.beat), 64'd1);
    endtask

    // Scoreboard: every note_valid pops one expected frame.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.note_valid) begin
                valid_seen++;
                check("valid_after_beat", 64'(prev_beat), 64'd1);
                if (exp_q.size() == 0) check("unexpected_valid", 64'(exp_q.size()), 64'd1);
                else                   check("frame", 64'(bus.note_out), 64'(exp_q.pop_front()));
            end
            prev_beat = bus.beat;
        end else begin
            prev_beat = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        logic [NS-1:0] win_s [DEPTH];
        logic [NB-1:0] win_b [DEPTH];

        bus.cmd_record = 1'b0;
        bus.cmd_play   = 1'b0;
        bus.cmd_stop   = 1'b0;
        bus.loop_en    = 1'b0;
        bus.speed      = 3'd4;
        bus.strings    = '0;
        bus.bars       = '0;

        repeat (2) @(negedge clk);
        check("rst_state",      64'(bus.state),      64'd0);
        check("rst_note_out",   64'(bus.note_out),   64'd0);
        check("rst_note_valid", 64'(bus.note_valid), 64'd0);
        check("rst_beat",       64'(bus.beat),       64'd0);
        check("rst_rec_len",    64'(bus.rec_len),    64'd0);
        check("rst_full",       64'(bus.full),       64'd0);
        resetn = 1'b1;

        pulse(1'b0, 1'b1, 1'b0);
        check("play_no_rec_ignored", 64'(bus.state), 64'd0);
        pulse(1'b1, 1'b0, 1'b1);
        check("rec_and_stop_ignored", 64'(bus.state), 64'd0);

        // String 0 held, no bar, three beats then stop.
        bus.strings = 6'b000001;
        pulse(1'b1, 1'b0, 1'b0);
        check("rec1_state", 64'(bus.state), 64'd1);
        for (int i = 0; i < 3; i++) begin
            wait_beat(n);
            check("rec1_beat_spacing", 64'(n), 64'd5);
            model_mem[i] = encode(bus.strings, bus.bars);
        end
        pulse(1'b0, 1'b0, 1'b1);
        bus.strings = '0;
        check("rec1_rec_len", 64'(bus.rec_len), 64'd3);
        check("rec1_full",    64'(bus.full),    64'd0);
        check("rec1_idle",    64'(bus.state),   64'd0);

        // One-shot playback of the three frames.
        bus.loop_en = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(model_mem[i]);
        pulse(1'b0, 1'b1, 1'b0);
        check("play1_state", 64'(bus.state), 64'd2);
        for (int i = 0; i < 3; i++) begin
            wait_beat(n);
            check("play1_beat_spacing", 64'(n), 64'd5);
        end
        @(negedge clk);
        check("play1_end_idle",   64'(bus.state),      64'd0);
        check("play1_last_valid", 64'(bus.note_valid), 64'd1);
        repeat (3) @(negedge clk);
        check("play1_drained",     64'(exp_q.size()), 64'd0);
        check("play1_valid_count", 64'(valid_seen),   64'd3);

        // Bars 1 and 3 in one window: bar 3 dominates, string 1 -> bit 19.
        bus.strings = 6'b000010;
        bus.bars    = 4'b0001;
        pulse(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.bars = 4'b0100;
        @(posedge clk); #1;
        bus.strings = '0;
        bus.bars    = '0;
        wait_beat(n);
        check("rec2_beat", 64'(n), 64'd3);
        pulse(1'b0, 1'b0, 1'b1);
        check("rec2_rec_len", 64'(bus.rec_len), 64'd1);
        exp_q.push_back(24'h080000);
        pulse(1'b0, 1'b1, 1'b0);
        wait_beat(n);
        @(negedge clk);
        check("play2_end_idle", 64'(bus.state), 64'd0);
        @(negedge clk);
        check("play2_drained", 64'(exp_q.size()), 64'd0);

        // Fill all DEPTH entries; each window has its own string and bar.
        for (int i = 0; i < DEPTH; i++) begin
            win_s[i] = NS'(1 << i);
            win_b[i] = (i == 0) ? '0 : NB'(1 << (i - 1));
        end
        bus.strings = win_s[0];
        bus.bars    = win_b[0];
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            wait_beat(n);
            check("rec3_beat_spacing", 64'(n), 64'd5);
            model_mem[i] = encode(win_s[i], win_b[i]);
            bus.strings  = (i < DEPTH - 1) ? win_s[i+1] : '0;
            bus.bars     = (i < DEPTH - 1) ? win_b[i+1] : '0;
        end
        @(negedge clk);
        check("rec3_auto_idle", 64'(bus.state),   64'd0);
        check("rec3_full",      64'(bus.full),    64'd1);
        check("rec3_rec_len",   64'(bus.rec_len), 64'd4);
        check("rec3_beat_idle", 64'(bus.beat),    64'd0);

        // Looped playback: 0,1,2,3,0,1 then stop.
        bus.loop_en = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(model_mem[i % DEPTH]);
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            wait_beat(n);
            check("loop_beat_spacing", 64'(n), 64'd5);
        end
        pulse(1'b0, 1'b0, 1'b1);
        check("loop_stop_idle", 64'(bus.state), 64'd0);
        repeat (8) @(negedge clk);
        check("loop_note_hold", 64'(bus.note_out), 64'(model_mem[1]));
        check("loop_drained",   64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a recording.
        bus.loop_en = 1'b0;
        bus.strings = 6'h3F;
        pulse(1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("arst_state",    64'(bus.state),    64'd0);
        check("arst_rec_len",  64'(bus.rec_len),  64'd0);
        check("arst_full",     64'(bus.full),     64'd0);
        check("arst_note_out", 64'(bus.note_out), 64'd0);
        check("arst_beat",     64'(bus.beat),     64'd0);
        @(negedge clk);
        resetn      = 1'b1;
        bus.strings = '0;
        pulse(1'b0, 1'b1, 1'b0);
        check("arst_play_ignored", 64'(bus.state), 64'd0);
        repeat (10) @(negedge clk);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
